// File: rtl/reglist_pkg.sv
// Shared encodings and helpers for the PUSH/POP register-list sequencer.
package reglist_pkg;

  localparam int unsigned LIST_W_DEF     = 10;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned LIST_BIT_LRPC  = 8;
  localparam int unsigned CNT_W          = 4;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [3:0] LR_IDX = 4'd14;
  localparam logic [3:0] PC_IDX = 4'd15;

  // Number of registers named by the architectural part of the list (r0..r7, LR/PC).
  function automatic logic [CNT_W-1:0] popcount9(input logic [8:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/reglist_sequencer_if.sv
// Decode/LSU-facing bundle of the register-list sequencer.
interface reglist_sequencer_if #(
  parameter int unsigned LIST_W = 10,
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic [1:0]        push_pop;
  logic [LIST_W-1:0] list_in;
  logic [ADDR_W-1:0] sp_in;
  logic              mem_ready;
  logic              beat_valid;
  logic [3:0]        reg_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [LIST_W-1:0] list_remaining;
  logic              sp_we;
  logic [ADDR_W-1:0] sp_new;
  logic              busy;
  logic              done;

  modport master (
    output start, push_pop, list_in, sp_in, mem_ready,
    input  beat_valid, reg_addr, mem_addr, mem_we, list_remaining,
           sp_we, sp_new, busy, done
  );

  modport slave (
    input  start, push_pop, list_in, sp_in, mem_ready,
    output beat_valid, reg_addr, mem_addr, mem_we, list_remaining,
           sp_we, sp_new, busy, done
  );
endinterface

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit plus its one-hot mask.
module lsb_prio_enc #(
  parameter  int unsigned W     = 10,
  localparam int unsigned IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     list,
  output logic [IDX_W-1:0] idx_c,
  output logic [W-1:0]     mask_c
);

  always_comb begin
    idx_c = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (list[i]) idx_c = IDX_W'(i);
    end
  end

  assign mask_c = list & (~list + W'(1));

endmodule

// File: rtl/reglist_sequencer.sv
// PUSH/POP multi-register beat sequencer: one beat per list bit, lowest first, then SP writeback.
// Optional build macro REGLIST_EMPTY_DONE_EN: an empty-list start completes with a bare SP writeback.
module reglist_sequencer
  import reglist_pkg::*;
#(
  parameter int unsigned LIST_W     = LIST_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned WORD_BYTES = 4
) (
  input logic clk,
  input logic rst,
  reglist_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LIST_W);
  localparam logic [LIST_W-1:0] LIST_KEEP = LIST_W'((1 << (LIST_BIT_LRPC + 1)) - 1);

  logic [1:0]        state_q, state_d;
  logic [LIST_W-1:0] list_q, list_d, mask_q, mask_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d, sp_new_q, sp_new_d;
  logic              push_q, push_d;

  logic              beat_valid_q, mem_we_q, sp_we_q, busy_q, done_q;
  logic [3:0]        reg_addr_q, reg_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              start_ok;
  logic [CNT_W-1:0]  n;
  logic [ADDR_W-1:0] span;
  logic [IDX_W-1:0]  idx_nxt;

  assign start_ok = bus.start && (bus.push_pop == OP_PUSH || bus.push_pop == OP_POP);
  assign n        = popcount9(bus.list_in[LIST_BIT_LRPC:0]);
  assign span     = ADDR_W'(WORD_BYTES) * ADDR_W'(n);

  // Next-state, next list and transfer bookkeeping.
  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    k_d      = k_q;
    base_d   = base_q;
    push_d   = push_q;
    sp_new_d = sp_new_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if ((bus.list_in & LIST_KEEP) != '0) begin
            push_d   = (bus.push_pop == OP_PUSH);
            list_d   = bus.list_in & LIST_KEEP;
            k_d      = '0;
            base_d   = push_d ? bus.sp_in - span : bus.sp_in;
            sp_new_d = push_d ? bus.sp_in - span : bus.sp_in + span;
            state_d  = S_RUN;
          end
`ifdef REGLIST_EMPTY_DONE_EN
          else begin
            push_d   = (bus.push_pop == OP_PUSH);
            sp_new_d = bus.sp_in;
            state_d  = S_WB;
          end
`endif
        end
      end
      S_RUN: begin
        if (bus.mem_ready) begin
          list_d = list_q & ~mask_q;
          k_d    = k_q + CNT_W'(1);
          if ((list_q & ~mask_q) == '0) state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  lsb_prio_enc #(.W(LIST_W)) u_enc (
    .list   (list_d),
    .idx_c  (idx_nxt),
    .mask_c (mask_d)
  );

  // Beat payload is precomputed from next-cycle state so every output leaves a flop.
  always_comb begin
    reg_addr_d = '0;
    mem_addr_d = '0;
    if (state_d == S_RUN) begin
      if (idx_nxt == IDX_W'(LIST_BIT_LRPC)) reg_addr_d = push_d ? LR_IDX : PC_IDX;
      else                                  reg_addr_d = 4'(idx_nxt);
      mem_addr_d = base_d + ADDR_W'(WORD_BYTES) * ADDR_W'(k_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      list_q       <= '0;
      mask_q       <= '0;
      k_q          <= '0;
      base_q       <= '0;
      push_q       <= 1'b0;
      sp_new_q     <= '0;
      beat_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      sp_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reg_addr_q   <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      list_q       <= list_d;
      mask_q       <= mask_d;
      k_q          <= k_d;
      base_q       <= base_d;
      push_q       <= push_d;
      sp_new_q     <= sp_new_d;
      beat_valid_q <= (state_d == S_RUN);
      mem_we_q     <= (state_d == S_RUN) && push_d;
      sp_we_q      <= (state_d == S_WB);
      done_q       <= (state_d == S_WB);
      busy_q       <= (state_d != S_IDLE);
      reg_addr_q   <= reg_addr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign bus.beat_valid     = beat_valid_q;
  assign bus.reg_addr       = reg_addr_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.list_remaining = list_q;
  assign bus.sp_we          = sp_we_q;
  assign bus.sp_new         = sp_new_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_reglist_sequencer.sv
// Directed self-checking bench for reglist_sequencer.
module tb_reglist_sequencer;
  import reglist_pkg::*;

  localparam int unsigned LIST_W = 10;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  reglist_sequencer_if #(.LIST_W(LIST_W), .ADDR_W(ADDR_W)) bus ();

  reglist_sequencer #(.LIST_W(LIST_W), .ADDR_W(ADDR_W), .WORD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.push_pop = 2'b00; bus.list_in = '0; bus.sp_in = '0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.mem_we, bus.list_remaining,
         bus.sp_we, bus.sp_new, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%0d a=%h we=%b lr=%h spwe=%b sp=%h busy=%b done=%b, want all 0",
               bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.mem_we, bus.list_remaining,
               bus.sp_we, bus.sp_new, bus.busy, bus.done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.beat_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b v=%b done=%b, want 0 0 0", bus.busy, bus.beat_valid, bus.done);
    end
  endtask

  task automatic test_push();
    logic [3:0]  ra [3];
    logic [31:0] ma [3];
    ra[0] = 4'd0; ra[1] = 4'd4; ra[2] = 4'd14;
    ma[0] = 32'h200000F4; ma[1] = 32'h200000F8; ma[2] = 32'h200000FC;
    bus.mem_ready = 1'b1;
    bus.start = 1'b1; bus.push_pop = OP_PUSH; bus.list_in = 10'h111; bus.sp_in = 32'h2000_0100;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.beat_valid !== 1'b1 || bus.reg_addr !== ra[i] || bus.mem_addr !== ma[i] ||
          bus.mem_we !== 1'b1 || bus.busy !== 1'b1 || bus.sp_we !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL push_beat%0d: got v=%b r=%0d a=%h we=%b busy=%b spwe=%b done=%b, want v=1 r=%0d a=%h we=1 busy=1 spwe=0 done=0",
                 i, bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.mem_we, bus.busy, bus.sp_we, bus.done, ra[i], ma[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.beat_valid !== 1'b0 || bus.sp_we !== 1'b1 || bus.sp_new !== 32'h200000F4 ||
        bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL push_wb: got v=%b spwe=%b sp=%h done=%b busy=%b, want v=0 spwe=1 sp=200000f4 done=1 busy=1",
               bus.beat_valid, bus.sp_we, bus.sp_new, bus.done, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.sp_we !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL push_end: got done=%b spwe=%b busy=%b, want 0 0 0", bus.done, bus.sp_we, bus.busy);
    end
  endtask

  task automatic test_pop();
    logic [3:0]  ra [2];
    logic [31:0] ma [2];
    ra[0] = 4'd1; ra[1] = 4'd15;
    ma[0] = 32'h20000100; ma[1] = 32'h20000104;
    bus.mem_ready = 1'b1;
    bus.start = 1'b1; bus.push_pop = OP_POP; bus.list_in = 10'h102; bus.sp_in = 32'h2000_0100;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.beat_valid !== 1'b1 || bus.reg_addr !== ra[i] || bus.mem_addr !== ma[i] || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL pop_beat%0d: got v=%b r=%0d a=%h we=%b, want v=1 r=%0d a=%h we=0",
                 i, bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.mem_we, ra[i], ma[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.sp_we !== 1'b1 || bus.sp_new !== 32'h20000108 || bus.done !== 1'b1 || bus.beat_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_wb: got spwe=%b sp=%h done=%b v=%b, want spwe=1 sp=20000108 done=1 v=0",
               bus.sp_we, bus.sp_new, bus.done, bus.beat_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    bus.mem_ready = 1'b0;
    bus.start = 1'b1; bus.push_pop = OP_PUSH; bus.list_in = 10'h00C; bus.sp_in = 32'h0000_1000;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.beat_valid !== 1'b1 || bus.reg_addr !== 4'd2 || bus.mem_addr !== 32'h00000FF8 ||
          bus.list_remaining !== 10'h00C) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b r=%0d a=%h lr=%h, want v=1 r=2 a=00000ff8 lr=00c",
                 i, bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.list_remaining);
      end
      if (i == 3) bus.mem_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bus.beat_valid !== 1'b1 || bus.reg_addr !== 4'd3 || bus.mem_addr !== 32'h00000FFC ||
        bus.list_remaining !== 10'h008) begin
      errors++;
      $display("FAIL stall_second: got v=%b r=%0d a=%h lr=%h, want v=1 r=3 a=00000ffc lr=008",
               bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.list_remaining);
    end
    @(negedge clk);
    checks++;
    if (bus.sp_we !== 1'b1 || bus.sp_new !== 32'h00000FF8 || bus.done !== 1'b1 || bus.list_remaining !== 10'h000) begin
      errors++;
      $display("FAIL stall_wb: got spwe=%b sp=%h done=%b lr=%h, want spwe=1 sp=00000ff8 done=1 lr=000",
               bus.sp_we, bus.sp_new, bus.done, bus.list_remaining);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int done_cnt;
    done_cnt = 0;
    bus.mem_ready = 1'b1;
    bus.start = 1'b1; bus.push_pop = OP_PUSH; bus.list_in = 10'h006; bus.sp_in = 32'h0000_0300;
    @(negedge clk);
    bus.push_pop = OP_POP; bus.list_in = 10'h0F0; bus.sp_in = 32'h0000_0999;
    checks++;
    if (bus.reg_addr !== 4'd1 || bus.mem_addr !== 32'h000002F8 || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL busy_beat0: got r=%0d a=%h we=%b, want r=1 a=000002f8 we=1", bus.reg_addr, bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.reg_addr !== 4'd2 || bus.mem_addr !== 32'h000002FC || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL busy_beat1: got r=%0d a=%h we=%b, want r=2 a=000002fc we=1", bus.reg_addr, bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    checks++;
    if (bus.sp_we !== 1'b1 || bus.sp_new !== 32'h000002F8 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL busy_wb: got spwe=%b sp=%h done=%b, want spwe=1 sp=000002f8 done=1", bus.sp_we, bus.sp_new, bus.done);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL busy_single_done: got %0d cycles of extra activity, want 0", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    bus.mem_ready = 1'b1;
    bus.start = 1'b1; bus.push_pop = OP_POP; bus.list_in = 10'h00E; bus.sp_in = 32'h0000_0500;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.reg_addr !== 4'd2 || bus.mem_addr !== 32'h00000504) begin
      errors++;
      $display("FAIL rstmid_beat1: got r=%0d a=%h, want r=2 a=00000504", bus.reg_addr, bus.mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.list_remaining, bus.sp_we, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%b r=%0d a=%h lr=%h spwe=%b busy=%b done=%b, want all 0",
               bus.beat_valid, bus.reg_addr, bus.mem_addr, bus.list_remaining, bus.sp_we, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.sp_we !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rstmid_idle: got %0d active cycles after reset, want 0", bad);
    end
  endtask

  task automatic test_invalid_op();
    logic [1:0] ops [2];
    ops[0] = 2'b00; ops[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.push_pop = ops[i]; bus.list_in = 10'h003; bus.sp_in = 32'h0000_0800;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.beat_valid !== 1'b0 || bus.sp_we !== 1'b0) begin
        errors++;
        $display("FAIL invalid_op_%b: got busy=%b v=%b spwe=%b, want 0 0 0", ops[i], bus.busy, bus.beat_valid, bus.sp_we);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    bus.mem_ready = 1'b1;
    bus.start = 1'b1; bus.push_pop = OP_PUSH; bus.list_in = 10'h001; bus.sp_in = 32'h0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.reg_addr !== 4'd0 || bus.mem_addr !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL wrap_beat: got r=%0d a=%h, want r=0 a=fffffffc", bus.reg_addr, bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.sp_we !== 1'b1 || bus.sp_new !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL wrap_wb: got spwe=%b sp=%h, want spwe=1 sp=fffffffc", bus.sp_we, bus.sp_new);
    end
    @(negedge clk);
  endtask

  task automatic test_empty();
    bus.start = 1'b1; bus.push_pop = OP_PUSH; bus.list_in = 10'h200; bus.sp_in = 32'h0000_0100;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
`ifdef REGLIST_EMPTY_DONE_EN
    if (bus.sp_we !== 1'b1 || bus.sp_new !== 32'h00000100 || bus.done !== 1'b1 || bus.beat_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_wb: got spwe=%b sp=%h done=%b v=%b, want spwe=1 sp=00000100 done=1 v=0",
               bus.sp_we, bus.sp_new, bus.done, bus.beat_valid);
    end
`else
    if (bus.sp_we !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.beat_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_ignored: got spwe=%b done=%b busy=%b v=%b, want 0 0 0 0",
               bus.sp_we, bus.done, bus.busy, bus.beat_valid);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_invalid_op();
    test_wrap();
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
